// File: rtl/fifo_bist_pkg.sv
// Shared types and constants for the fifo_bist traffic source/sink.
// Pattern selection is controlled by the FIFO_BIST_LFSR_EN macro (see fifo_bist_pattern).
package fifo_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Galois feedback mask for x^32+x^22+x^2+x+1 (right-shifting form)
   localparam logic [31:0] LFSR_POLY   = 32'h8020_0003;
   localparam int          DEF_SEED    = 1;
   localparam int          DEF_TIMEOUT = 100;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
   endfunction

endpackage

// File: rtl/fifo_bist_pattern.sv
// Pattern generator: one word per advance, reloaded to SEED on load/reset.
// FIFO_BIST_LFSR_EN defined  -> 32-bit Galois LFSR.
// FIFO_BIST_LFSR_EN undefined -> incrementing counter (wraps modulo 2^DATA_WIDTH).
module fifo_bist_pattern
   import fifo_bist_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] SEED       = 32'd1
) (
   input  logic                  clk,
   input  logic                  reset_i,
   input  logic                  load_i,
   input  logic                  advance_i,
   output logic [DATA_WIDTH-1:0] word_o
);

   logic [31:0] state_q;
   logic [31:0] state_d;

`ifdef FIFO_BIST_LFSR_EN
   assign state_d = lfsr_step(state_q);
`else
   // Low DATA_WIDTH bits of a 32-bit count wrap modulo 2^DATA_WIDTH
   assign state_d = state_q + 32'd1;
`endif

   // Generator state: reload wins over advance
   always_ff @(posedge clk) begin
      if (reset_i || load_i) state_q <= SEED;
      else if (advance_i)    state_q <= state_d;
   end

   assign word_o = state_q[DATA_WIDTH-1:0];

endmodule

// File: rtl/fifo_bist.sv
// FIFO self-test source/sink: one FILL-then-DRAIN pass per start pulse,
// checking pop order/data against a regenerated pattern.
// Build option: FIFO_BIST_LFSR_EN selects the LFSR pattern instead of a counter.
module fifo_bist
   import fifo_bist_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int CNT_WIDTH   = 8,
   parameter int FULL_CYCLES = 2,
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter int SEED        = DEF_SEED
) (
   input  logic                  clk,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic [CNT_WIDTH-1:0]  burst_len_i,
   output logic [DATA_WIDTH-1:0] push_data_o,
   output logic                  push_valid_o,
   input  logic                  push_ready_i,
   input  logic [DATA_WIDTH-1:0] pop_data_i,
   input  logic                  pop_valid_i,
   output logic                  pop_ready_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  pass_o,
   output logic [CNT_WIDTH-1:0]  pushed_o,
   output logic [CNT_WIDTH-1:0]  err_count_o
);

   localparam int IDLE_W = $clog2(TIMEOUT + 1);
   localparam int FULL_W = $clog2(FULL_CYCLES + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   state_e                state_q;
   logic [CNT_WIDTH-1:0]  blen_q, pushed_q, popped_q, err_q;
   logic [IDLE_W-1:0]     idle_q;
   logic [FULL_W-1:0]     full_q;
   logic                  push_valid_q, pop_ready_q, busy_q, done_q;
   logic                  timeout_q, overrun_q;

   logic [DATA_WIDTH-1:0] exp_word;
   logic                  start_ok, push_fire, pop_fire, mismatch;
   logic                  fill_end, full_hit, idle_hit;
   logic [CNT_WIDTH-1:0]  pushed_d, popped_d, err_d;

   assign start_ok  = start_i && (state_q == ST_IDLE || state_q == ST_DONE);
   assign push_fire = push_valid_q && push_ready_i;
   assign pop_fire  = pop_valid_i && pop_ready_q;
   assign mismatch  = pop_fire && (pop_data_i != exp_word);

   // Saturating counters never wrap back to zero
   assign pushed_d = (push_fire && pushed_q != CNT_MAX) ? pushed_q + 1'b1 : pushed_q;
   assign popped_d = (pop_fire  && popped_q != CNT_MAX) ? popped_q + 1'b1 : popped_q;
   assign err_d    = (mismatch  && err_q    != CNT_MAX) ? err_q    + 1'b1 : err_q;

   // burst_len 0 means "until full"; saturation also ends FILL in that mode
   assign fill_end = (blen_q != '0) ? (pushed_d == blen_q) : (pushed_d == CNT_MAX);
   assign full_hit = !push_ready_i && (full_q == FULL_W'(FULL_CYCLES - 1));
   assign idle_hit = !pop_fire && (idle_q == IDLE_W'(TIMEOUT - 1));

   fifo_bist_pattern #(.DATA_WIDTH(DATA_WIDTH), .SEED(32'(SEED))) u_tx (
      .clk(clk), .reset_i(reset_i), .load_i(start_ok), .advance_i(push_fire), .word_o(push_data_o)
   );

   fifo_bist_pattern #(.DATA_WIDTH(DATA_WIDTH), .SEED(32'(SEED))) u_exp (
      .clk(clk), .reset_i(reset_i), .load_i(start_ok), .advance_i(pop_fire), .word_o(exp_word)
   );

   // Pass sequencer: state, counters and registered handshake/status outputs
   always_ff @(posedge clk) begin
      if (reset_i) begin
         state_q      <= ST_IDLE;
         blen_q       <= '0;
         pushed_q     <= '0;
         popped_q     <= '0;
         err_q        <= '0;
         idle_q       <= '0;
         full_q       <= '0;
         push_valid_q <= 1'b0;
         pop_ready_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               // Anything still arriving after the pass closed means the FIFO held extra words
               if (state_q == ST_DONE && pop_valid_i) overrun_q <= 1'b1;
               if (start_ok) begin
                  state_q      <= ST_FILL;
                  blen_q       <= burst_len_i;
                  pushed_q     <= '0;
                  popped_q     <= '0;
                  err_q        <= '0;
                  idle_q       <= '0;
                  full_q       <= '0;
                  timeout_q    <= 1'b0;
                  overrun_q    <= 1'b0;
                  push_valid_q <= 1'b1;
                  busy_q       <= 1'b1;
                  done_q       <= 1'b0;
               end
            end
            ST_FILL: begin
               pushed_q <= pushed_d;
               full_q   <= push_ready_i ? '0 : full_q + 1'b1;
               if (fill_end || full_hit) begin
                  state_q      <= ST_DRAIN;
                  push_valid_q <= 1'b0;
                  pop_ready_q  <= 1'b1;
               end
            end
            ST_DRAIN: begin
               popped_q <= popped_d;
               err_q    <= err_d;
               idle_q   <= pop_fire ? '0 : idle_q + 1'b1;
               if (popped_d == pushed_q) begin
                  state_q     <= ST_DONE;
                  pop_ready_q <= 1'b0;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
               end else if (idle_hit) begin
                  state_q     <= ST_DONE;
                  pop_ready_q <= 1'b0;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  timeout_q   <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign push_valid_o = push_valid_q;
   assign pop_ready_o  = pop_ready_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign pass_o       = done_q && (err_q == '0) && !timeout_q && !overrun_q;
   assign pushed_o     = pushed_q;
   assign err_count_o  = err_q;

endmodule

// File: tb/tb_fifo_bist.sv
// Bench for fifo_bist: behavioural FIFO loops push side to pop side,
// scoreboard queues hold expected push words and expected pass results.
module tb_fifo_bist;

   localparam int DW   = 32;
   localparam int CW   = 8;
   localparam int TO   = 100;
   localparam int SEED = 1;

   logic          clk = 1'b0;
   logic          reset_i, start_i;
   logic [CW-1:0] burst_len_i;
   logic [DW-1:0] push_data_o, pop_data_i;
   logic          push_valid_o, push_ready_i, pop_valid_i, pop_ready_o;
   logic          busy_o, done_o, pass_o;
   logic [CW-1:0] pushed_o, err_count_o;

   fifo_bist #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .FULL_CYCLES(2), .TIMEOUT(TO), .SEED(SEED)) dut (
      .clk(clk), .reset_i(reset_i), .start_i(start_i), .burst_len_i(burst_len_i),
      .push_data_o(push_data_o), .push_valid_o(push_valid_o), .push_ready_i(push_ready_i),
      .pop_data_i(pop_data_i), .pop_valid_i(pop_valid_i), .pop_ready_o(pop_ready_o),
      .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
      .pushed_o(pushed_o), .err_count_o(err_count_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic pass;
      int   pushed;
      int   err;
   } res_t;

   res_t        res_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] fq[$];

   int n_chk = 0, n_fail = 0;
   int cyc = 0;
   int depth = 8;
   bit rnd_en = 0, chk_push = 1;
   int vld_lim = 1 << 30;
   int flip_a = -1, flip_b = -1;
   int n_push = 0, n_pop = 0, last_pop_cyc = 0, done_cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_lfsr(input logic [31:0] s);
      logic [31:0] r;
      logic fb;
      fb = s[0];
      r  = s >> 1;
      if (fb) begin
         r[31] = ~r[31]; r[21] = ~r[21]; r[1] = ~r[1]; r[0] = ~r[0];
      end
      return r;
   endfunction

   // Expected i-th word of a pass
   function automatic logic [31:0] exp_word(input int i);
`ifdef FIFO_BIST_LFSR_EN
      logic [31:0] tbl [6];
      logic [31:0] s;
      tbl[0] = 32'h0000_0001; tbl[1] = 32'h8020_0003; tbl[2] = 32'hC030_0002;
      tbl[3] = 32'h6018_0001; tbl[4] = 32'hB02C_0003; tbl[5] = 32'hD836_0002;
      if (i < 6) return tbl[i];
      s = tbl[5];
      for (int k = 5; k < i; k++) s = ref_lfsr(s);
      return s;
`else
      return 32'(SEED + i);
`endif
   endfunction

   initial cycle_cnt: forever begin @(posedge clk); cyc++; end

   // Behavioural FIFO: transfers decided from mid-cycle values, applied after the edge
   initial begin : fifo_model
      bit pf, qf, rdy, prev_low, vld;
      logic [31:0] pd;
      push_ready_i = 1'b0; pop_valid_i = 1'b0; pop_data_i = '0; prev_low = 1'b0;
      forever begin
         @(negedge clk);
         pf = push_valid_o && push_ready_i;
         qf = pop_valid_i && pop_ready_o;
         pd = push_data_o;
         if (qf) last_pop_cyc = cyc;
         @(posedge clk);
         #1;
         if (pf) begin fq.push_back(pd); n_push++; end
         if (qf && fq.size() > 0) begin void'(fq.pop_front()); n_pop++; end
         // ready gaps never last two cycles, so random stalls never look like "full"
         rdy = !rnd_en || prev_low || ($urandom_range(0, 1) == 1);
         prev_low = !rdy;
         vld = (!rnd_en || ($urandom_range(0, 1) == 1)) && (n_pop < vld_lim);
         push_ready_i = (fq.size() < depth) && rdy;
         pop_valid_i  = (fq.size() > 0) && vld;
         pop_data_i   = (fq.size() > 0) ? (fq[0] ^ ((n_pop == flip_a || n_pop == flip_b) ? 32'd1 : 32'd0)) : '0;
      end
   end

   // Monitor: checks every push word and every completed pass against the scoreboard
   initial begin : monitor
      bit   dprev;
      res_t r;
      dprev = 1'b0;
      forever begin
         @(negedge clk);
         if (push_valid_o && push_ready_i && chk_push) begin
            if (exp_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL push_extra: got word %0h expected no push", push_data_o);
            end else chk("push_data", push_data_o, exp_q.pop_front());
         end
         if (done_o && !dprev) begin
            done_cyc = cyc;
            if (res_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL done_unexpected: got done_o=1 expected 0");
            end else begin
               r = res_q.pop_front();
               chk("pass_o", pass_o, r.pass);
               chk("pushed_o", pushed_o, r.pushed);
               chk("err_count_o", err_count_o, r.err);
            end
         end
         dprev = done_o;
      end
   end

   task automatic chk_reset_outs();
      chk("rst_flags", {push_valid_o, pop_ready_o, busy_o, done_o, pass_o}, 0);
      chk("rst_pushed", pushed_o, 0);
      chk("rst_err", err_count_o, 0);
   endtask

   task automatic run_pass(input int blen, input int n_exp, input int err, input bit pass, input int pops);
      n_push = 0; n_pop = 0;
      for (int i = 0; i < n_exp; i++) exp_q.push_back(exp_word(i));
      res_q.push_back('{pass, n_exp, err});
      @(negedge clk);
      burst_len_i = CW'(blen);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      chk("start_busy_done", {busy_o, done_o}, 2'b10);
      for (int k = 0; k < 5000 && res_q.size() != 0; k++) @(negedge clk);
      #1;
      if (res_q.size() != 0) begin
         n_chk++; n_fail++;
         $display("FAIL pass_timeout: got no done_o expected done within 5000 cycles");
         res_q.delete();
      end
      chk("exp_left", exp_q.size(), 0);
      exp_q.delete();
      chk("pop_count", n_pop, pops);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got no finish expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      reset_i = 1'b1; start_i = 1'b0; burst_len_i = '0;
      repeat (3) @(negedge clk);
      chk_reset_outs();
      reset_i = 1'b0;

      // 1: fill until full, drain 8
      run_pass(0, 8, 0, 1'b1, 8);
      // 2: bounded burst
      run_pass(5, 5, 0, 1'b1, 5);

      // overrun: an extra word shows up while DONE
      @(negedge clk);
      fq.push_back(32'h0000_1234);
      repeat (3) @(negedge clk);
      chk("overrun_done", done_o, 1);
      chk("overrun_pass", pass_o, 0);
      fq.delete();
      repeat (3) @(negedge clk);

      // 3: corrupt 2nd and 4th popped word
      flip_a = 1; flip_b = 3;
      run_pass(0, 8, 2, 1'b0, 8);
      flip_a = -1; flip_b = -1;

      // 4: pop side stalls after 3 words
      vld_lim = 3;
      run_pass(0, 8, 0, 1'b0, 3);
      chk("timeout_latency", done_cyc - last_pop_cyc - 1, TO);
      fq.delete();
      repeat (2) @(negedge clk);
      vld_lim = 1 << 30;

      // 5: random gaps on a deeper FIFO
      depth = 32; rnd_en = 1;
      run_pass(20, 20, 0, 1'b1, 20);
      rnd_en = 0; depth = 8;
      repeat (2) @(negedge clk);

      // 6: reset in the middle of FILL, then a clean pass
      chk_push = 0; n_push = 0;
      burst_len_i = '0; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      for (int k = 0; k < 100 && n_push < 3; k++) @(negedge clk);
      chk("mid_fill_busy", busy_o, 1);
      reset_i = 1'b1;
      @(negedge clk);
      chk_reset_outs();
      reset_i = 1'b0;
      fq.delete();
      repeat (2) @(negedge clk);
      chk_push = 1;
      run_pass(0, 8, 0, 1'b1, 8);

      // 7: FIFO never fills -> pushed saturates at all-ones
      depth = 300;
      run_pass(0, 255, 0, 1'b1, 255);
      depth = 8;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
